// File: rtl/rs485_rx_deframer.sv
// rs485_rx_deframer: oversampled 8N1 receiver with FWFT byte FIFO and idle-gap frame detection
module rs485_rx_deframer #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_BITS   = 35
) (
  input  logic                        clk25,
  input  logic                        reset,
  input  logic                        rx_in,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_end,
  output logic                        frame_err,
  output logic                        overflow,
  output logic                        busy
);
  localparam int DIV = CLK_HZ / (BAUD * OSR);
  localparam int TW  = $clog2(DIV);
  localparam int OW  = $clog2(OSR);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int GW  = $clog2(GAP_BITS + 1);
  localparam int MID = OSR / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [OW-1:0] os_q, os_d;
  logic [1:0]    smp_q, smp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [OW-1:0] gtk_q, gtk_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          fend_q, fend_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic          tick, fall, dec, maj, push, pop, wr;
  assign tick       = tcnt_q == TW'(DIV - 1);
  assign fall       = s3_q & ~s2_q;
  assign dec        = tick && os_q == OW'(MID + 1);
  // majority of the samples at ticks MID-1, MID and the live line at MID+1
  assign maj        = (smp_q[1] & smp_q[0]) | (smp_q[1] & s2_q) | (smp_q[0] & s2_q);
  assign rx_valid   = cnt_q != '0;
  assign pop        = rx_valid & rx_ready;
  assign wr         = push && (cnt_q != (AW+1)'(FIFO_DEPTH) || pop);
  assign rx_data    = rx_valid ? mem_q[rp_q] : '0;
  assign fifo_count = cnt_q;
  assign frame_end  = fend_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    tcnt_d  = (tick || (state_q == IDLE && fall)) ? '0 : tcnt_q + TW'(1);
    os_d    = !tick ? os_q : os_q == OW'(OSR - 1) ? '0 : os_q + OW'(1);
    smp_d   = (tick && os_q == OW'(MID - 1)) ? {s2_q, smp_q[0]} :
              (tick && os_q == OW'(MID))     ? {smp_q[1], s2_q} : smp_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        os_d    = '0;
      end
      START: if (dec) begin
        state_d = maj ? IDLE : DATA;
        bit_d   = '0;
      end
      DATA: if (dec) begin
        sh_d    = {maj, sh_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (dec) begin
        push    = maj;
        ferr_d  = ~maj;
        state_d = maj ? IDLE : WAIT_HIGH;
        os_d    = '0;
      end
      WAIT_HIGH: if (tick) begin
        os_d    = s2_q ? os_q + OW'(1) : '0;
        state_d = (s2_q && os_q == OW'(OSR - 1)) ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    armed_d = armed_q;
    gtk_d   = gtk_q;
    gap_d   = gap_q;
    fend_d  = 1'b0;
    if (state_q == IDLE && fall) begin
      gtk_d = '0;
      gap_d = '0;
    end else if (armed_q && state_q == IDLE && s2_q && tick) begin
      gtk_d = gtk_q == OW'(OSR - 1) ? '0 : gtk_q + OW'(1);
      if (gtk_q == OW'(OSR - 1)) begin
        gap_d   = gap_q == GW'(GAP_BITS - 1) ? '0 : gap_q + GW'(1);
        fend_d  = gap_q == GW'(GAP_BITS - 1);
        armed_d = gap_q != GW'(GAP_BITS - 1);
      end
    end
    if (push) begin
      armed_d = 1'b1;
      gtk_d   = '0;
      gap_d   = '0;
    end
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = ovf_q | (push & ~wr);
  end
  always_ff @(posedge clk25) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      os_q    <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      gtk_q   <= '0;
      gap_q   <= '0;
      fend_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= rx_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      os_q    <= os_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wp_q    <= wp_q + AW'(wr);
      rp_q    <= rp_q + AW'(pop);
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      gtk_q   <= gtk_d;
      gap_q   <= gap_d;
      fend_q  <= fend_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk25) begin
    if (wr) mem_q[wp_q] <= sh_q;
  end
endmodule

// File: tb/tb_rs485_rx_deframer.sv
// tb_rs485_rx_deframer: directed checks of byte recovery, FIFO, framing errors and idle-gap detection
`timescale 1ns/1ps
module tb_rs485_rx_deframer;
  localparam int CLK_HZ = 614400;
  localparam int BIT    = 64;
  logic       clk25 = 1'b0, reset = 1'b1, rx_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [4:0] fifo_count;
  logic       rx_valid, frame_end, frame_err, overflow, busy;
  int         checks = 0, failures = 0;
  int         cyc = 0, fend_n = 0, ferr_n = 0, vld_n = 0, fend_cyc = 0;
  int         base, fbase, ebase, vbase, tl;
  logic [7:0] got_q[$];
  rs485_rx_deframer #(.CLK_HZ(CLK_HZ)) dut (
    .clk25(clk25), .reset(reset), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .frame_end(frame_end), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );
  always #5 clk25 = ~clk25;
  always @(posedge clk25) cyc <= cyc + 1;
  always @(negedge clk25) begin
    #1;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) vld_n++;
    if (frame_err) ferr_n++;
    if (frame_end) begin
      fend_n++;
      fend_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (BIT) @(negedge clk25);
    end
  endtask
  task automatic do_reset();
    @(negedge clk25);
    reset = 1'b1;
    @(negedge clk25);
    reset = 1'b0;
    rx_in = 1'b1;
  endtask
  task automatic snap();
    base  = got_q.size();
    fbase = fend_n;
    ebase = ferr_n;
    vbase = vld_n;
  endtask
  initial begin
    repeat (3) @(negedge clk25);
    reset = 1'b0;
    @(negedge clk25);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fend", frame_end, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_data", rx_data, 0);
    // T1 single byte, consumer always ready
    do_reset();
    rx_ready = 1'b1;
    snap();
    send_byte(8'hA5, 1'b1);
    repeat (32) @(negedge clk25);
    chk("t1_npop", got_q.size() - base, 1);
    chk("t1_data", got_q[base], 8'hA5);
    chk("t1_vcycles", vld_n - vbase, 1);
    chk("t1_count", fifo_count, 0);
    chk("t1_ferr", ferr_n - ebase, 0);
    // T2 short low glitch is rejected
    do_reset();
    snap();
    rx_in = 1'b0;
    repeat (8) @(negedge clk25);
    chk("t2_busy_hi", busy, 1);
    repeat (4) @(negedge clk25);
    rx_in = 1'b1;
    repeat (100) @(negedge clk25);
    chk("t2_busy_lo", busy, 0);
    chk("t2_npop", got_q.size() - base, 0);
    chk("t2_ferr", ferr_n - ebase, 0);
    // T3 bad stop bit, then a good byte
    do_reset();
    rx_ready = 1'b0;
    snap();
    send_byte(8'h3C, 1'b0);
    rx_in = 1'b1;
    repeat (2 * BIT) @(negedge clk25);
    chk("t3_ferr", ferr_n - ebase, 1);
    chk("t3_count0", fifo_count, 0);
    send_byte(8'h11, 1'b1);
    repeat (8) @(negedge clk25);
    chk("t3_count1", fifo_count, 1);
    chk("t3_data", rx_data, 8'h11);
    chk("t3_ferr_once", ferr_n - ebase, 1);
    // T4 overflow on 17th byte, in-order drain
    do_reset();
    rx_ready = 1'b0;
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    chk("t4_full", fifo_count, 16);
    chk("t4_ovf_before", overflow, 0);
    send_byte(8'h10, 1'b1);
    repeat (8) @(negedge clk25);
    chk("t4_count", fifo_count, 16);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", rx_data, 8'h00);
    rx_ready = 1'b1;
    repeat (40) @(negedge clk25);
    chk("t4_ndrain", got_q.size() - base, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t4_drain%0d", i), (got_q.size() > base + i) ? got_q[base + i] : 8'hEE, 8'(i));
    chk("t4_empty", fifo_count, 0);
    chk("t4_ovf_sticky", overflow, 1);
    // T5 idle-gap frame_end after a burst
    do_reset();
    rx_ready = 1'b1;
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    tl = cyc;
    chk("t5_nofend_between", fend_n - fbase, 0);
    for (int i = 0; i < 3000 && fend_n == fbase; i++) @(negedge clk25);
    chk("t5_fend_seen", fend_n - fbase, 1);
    chk("t5_delay_window", (fend_cyc - tl > 2150) && (fend_cyc - tl < 2310), 1);
    repeat (2000) @(negedge clk25);
    chk("t5_fend_once", fend_n - fbase, 1);
    chk("t5_npop", got_q.size() - base, 3);
    chk("t5_last", got_q[got_q.size() - 1], 8'h03);
    // T6 reset mid-byte with two bytes queued
    do_reset();
    rx_ready = 1'b0;
    snap();
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    chk("t6_queued", fifo_count, 2);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk25);
    rx_in = 1'b0;
    repeat (4 * BIT) @(negedge clk25);
    rx_in = 1'b1;
    repeat (BIT / 2) @(negedge clk25);
    chk("t6_busy_mid", busy, 1);
    reset = 1'b1;
    @(negedge clk25);
    reset = 1'b0;
    chk("t6_valid", rx_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_busy", busy, 0);
    repeat (2 * BIT) @(negedge clk25);
    rx_ready = 1'b1;
    snap();
    send_byte(8'h5A, 1'b1);
    repeat (16) @(negedge clk25);
    chk("t6_npop", got_q.size() - base, 1);
    chk("t6_data", got_q[got_q.size() - 1], 8'h5A);
    // T7 simultaneous pop and push on a full FIFO
    do_reset();
    rx_ready = 1'b0;
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
    chk("t7_full", fifo_count, 16);
    fork
      send_byte(8'h30, 1'b1);
      begin
        repeat (618) @(negedge clk25);
        rx_ready = 1'b1;
        @(negedge clk25);
        rx_ready = 1'b0;
      end
    join
    repeat (8) @(negedge clk25);
    chk("t7_count", fifo_count, 16);
    chk("t7_ovf", overflow, 0);
    chk("t7_head", rx_data, 8'h21);
    chk("t7_npop", got_q.size() - base, 1);
    rx_ready = 1'b1;
    repeat (40) @(negedge clk25);
    chk("t7_ndrain", got_q.size() - base, 17);
    chk("t7_tail", got_q[got_q.size() - 1], 8'h30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
